// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with grant timeout.
// Optional MEM_ARB_RR_EN: round-robin between simultaneous requesters (default: data has fixed priority).
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [31:0]       iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic [31:0]       dload,
  output logic              dhit,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_store,
  input  logic [31:0]       ram_load,
  input  logic              ram_ready,
  output logic              timeout_err
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             d_pend, grant_d, tmo, granted;
`ifdef MEM_ARB_RR_EN
  logic             last_d_q, last_d_d;  // 1: data won the previous arbitration
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    d_pend    = dREN | dWEN;
    grant_d   = d_pend;
    granted   = (state_q != IDLE);
    tmo       = TMO_EN && granted && !ram_ready && (cnt_q == CNT_LAST);
    iload     = '0;
    ihit      = 1'b0;
    dload     = '0;
    dhit      = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
`ifdef MEM_ARB_RR_EN
    last_d_d  = last_d_q;
    if (d_pend && iREN) grant_d = !last_d_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_pend || iREN) begin
          state_d = grant_d ? DGRANT : IGRANT;
`ifdef MEM_ARB_RR_EN
          last_d_d = grant_d;
`endif
        end
      end
      IGRANT: begin
        ram_ren  = 1'b1;
        ram_addr = iaddr;
        if (ram_ready) begin
          ihit    = 1'b1;
          iload   = ram_load;
          state_d = IDLE;
        end
      end
      DGRANT: begin
        ram_addr  = daddr;
        ram_store = dstore;
        ram_wen   = dWEN;
        ram_ren   = !dWEN;
        if (ram_ready) begin
          dhit    = 1'b1;
          dload   = ram_load;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completing ram_ready on the last allowed cycle wins over the timeout.
    if (tmo) begin
      terr_d  = 1'b1;
      state_d = IDLE;
    end
    if (granted && !ram_ready && !tmo && cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`endif

  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_load = 0;
  logic [31:0] iload, dload, ram_addr, ram_store;
  logic        ihit, dhit, ram_ren, ram_wen, timeout_err;

  int n_chk = 0, n_fail = 0;
  bit last_d = 0;   // model: data won the previous arbitration
  bit terr_m = 0;   // model: sticky timeout flag

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // One request from IDLE through completion/timeout plus the turnaround cycle.
  // lat = grant cycle index at which ram_ready rises.
  task automatic run_txn(input bit ir, input bit dr, input bit dw, input int lat,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] ld);
    bit win_d, hit_e, tmo_e, done;
    logic [35:0] obs, exp_v;
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ram_ready = 1'b1; ram_load = ld;  // ready must be ignored in IDLE
    win_d = dr || dw;
`ifdef MEM_ARB_RR_EN
    if ((dr || dw) && ir) win_d = !last_d;
`endif
    last_d = win_d;
    @(negedge CLK);
    n_chk++;
    obs = {ram_ren, ram_wen, ihit, dhit, ram_addr};
    if (obs !== 36'h0) begin
      n_fail++; $display("FAIL idle_arb: got %h want 0", obs);
    end
    @(posedge CLK); #1;
    done = 0;
    for (int k = 0; !done; k++) begin
      if (k > 3 * TMO) begin
        n_fail++; n_chk++; $display("FAIL grant_bound: no completion after %0d cycles", k);
        break;
      end
      ram_ready = (k == lat);
      @(negedge CLK);
      hit_e = (k == lat);
      tmo_e = !hit_e && (k == TMO - 1);
      exp_v = win_d ? {!dw, dw, 1'b0, hit_e, da} : {1'b1, 1'b0, hit_e, 1'b0, ia};
      obs = {ram_ren, ram_wen, ihit, dhit, ram_addr};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL grant_k%0d: got %h want %h", k, obs, exp_v);
      end
      if (win_d) begin
        n_chk++;
        if (ram_store !== ds) begin
          n_fail++; $display("FAIL ram_store: got %h want %h", ram_store, ds);
        end
      end
      if (hit_e && !(win_d && dw)) begin
        n_chk++;
        if ((win_d ? dload : iload) !== ld) begin
          n_fail++; $display("FAIL load_data: got %h want %h", win_d ? dload : iload, ld);
        end
      end
      if (tmo_e) terr_m = 1;
      done = hit_e || tmo_e;
      @(posedge CLK); #1;
    end
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    @(negedge CLK);
    n_chk++;
    obs = {ram_ren, ram_wen, ihit, dhit, 31'h0, timeout_err};
    if (obs !== {35'h0, terr_m}) begin
      n_fail++; $display("FAIL turnaround: got %h want %h", obs, {35'h0, terr_m});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    iREN = 1; dWEN = 1; ram_ready = 1; ram_load = 32'hFFFF_FFFF; iaddr = 32'h1; daddr = 32'h2;
    #12;
    n_chk++;
    if ({ram_ren, ram_wen, ihit, dhit, timeout_err, ram_addr, ram_store, iload, dload} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b%b%b%b%b want 0", ram_ren, ram_wen, ihit, dhit, timeout_err);
    end
    iREN = 0; dWEN = 0; ram_ready = 0;
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    last_d = 0; terr_m = 0;
  endtask

  task automatic test_fetch();
    run_txn(1, 0, 0, 2, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_contention();
    iREN = 1; dWEN = 1; iaddr = 32'h40; daddr = 32'h80; dstore = 32'h1234; ram_ready = 0;
    @(negedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    n_chk++;
    if ({ram_ren, ram_wen, dhit, ihit, ram_addr, ram_store} !== {4'b0100, 32'h80, 32'h1234}) begin
      n_fail++; $display("FAIL contention_dgrant: ren %b wen %b addr %h store %h want wen to 80 with 1234", ram_ren, ram_wen, ram_addr, ram_store);
    end
    @(posedge CLK); #1; ram_ready = 1;
    @(negedge CLK);
    n_chk++;
    if ({dhit, ihit} !== 2'b10) begin
      n_fail++; $display("FAIL contention_dhit: dhit %b ihit %b want 1 0", dhit, ihit);
    end
    @(posedge CLK); #1; dWEN = 0; ram_ready = 0;
    @(negedge CLK);
    n_chk++;
    if ({ram_ren, ram_wen, ihit, dhit} !== 4'b0) begin
      n_fail++; $display("FAIL contention_idle: got %b%b%b%b want 0000", ram_ren, ram_wen, ihit, dhit);
    end
    @(posedge CLK); #1; ram_ready = 1; ram_load = 32'h55;
    @(negedge CLK);
    n_chk++;
    if ({ram_ren, ram_wen, ihit, dhit, ram_addr, iload} !== {4'b1010, 32'h40, 32'h55}) begin
      n_fail++; $display("FAIL contention_igrant: ren %b ihit %b addr %h iload %h want 1 1 40 55", ram_ren, ihit, ram_addr, iload);
    end
    @(posedge CLK); #1; iREN = 0; ram_ready = 0;
    @(negedge CLK); @(posedge CLK); #1;
    last_d = 0;
  endtask

  task automatic test_write_priority();
    run_txn(0, 1, 1, 1, 32'h0, 32'hABC0, 32'h5A5A_0001, 32'h0);
  endtask

  task automatic test_timeout();
    run_txn(0, 1, 0, 100, 32'h0, 32'h200, 32'h0, 32'h0);  // RAM never responds
    run_txn(1, 0, 0, TMO - 1, 32'h44, 32'h0, 32'h0, 32'h0BAD_F00D);  // ready on last allowed cycle
    run_txn(0, 1, 0, 0, 32'h0, 32'h204, 32'h0, 32'h1111_2222);  // re-arbitrates, flag stays set
  endtask

  task automatic test_reset_mid();
    dREN = 1; daddr = 32'h99; ram_ready = 0;
    @(negedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    n_chk++;
    if (ram_ren !== 1'b1) begin
      n_fail++; $display("FAIL resetmid_grant: ram_ren %b want 1", ram_ren);
    end
    #2 RST = 1; #1;
    n_chk++;
    if ({ram_ren, ram_wen, ihit, dhit, timeout_err, ram_addr, ram_store, iload, dload} !== '0) begin
      n_fail++; $display("FAIL resetmid_outputs: ren %b dhit %b terr %b addr %h want 0", ram_ren, dhit, timeout_err, ram_addr);
    end
    dREN = 0;
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_chk++;
    if ({ram_ren, ram_wen, ihit, dhit, timeout_err} !== 5'b0) begin
      n_fail++; $display("FAIL resetmid_idle: got %b%b%b%b%b want 0", ram_ren, ram_wen, ihit, dhit, timeout_err);
    end
    @(posedge CLK); #1;
    last_d = 0; terr_m = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit ir, dr, dw;
      do begin
        ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      end while (!(ir || dr || dw));
      run_txn(ir, dr, dw, int'($urandom_range(0, TMO + 1)),
              $urandom, $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_write_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
